// File: rtl/arb_pkg.sv
// Shared constants for the 8-way priority arbiter: requester count, id width,
// FSM state encoding and the default hold limit.
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int ID_W         = 3;
  localparam int MAX_HOLD_DEF = 16;

  // Two-state FSM encoding kept as plain constants for compatibility with
  // older tools that consume this package.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/arb_rotate_pick.sv
// Combinational wrap-around priority search. Starting at ptr and walking
// downward (7 wraps below 0), the first set request bit wins. With ptr=7 this
// is exactly the classic highest-index-wins 8-to-3 priority encoder.
module arb_rotate_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  logic [ID_W-1:0] idx;

  // Scan eight positions from ptr downward and keep the first hit only.
  always_comb begin
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr - ID_W'(i);
      if (!any && req[idx]) begin
        id  = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter8_priority_ctrl.sv
// Sequential 8-requester arbiter with registered one-hot grant, hold timeout
// and a mandatory dead cycle between grants.
// Optional macro ARB_ROUND_ROBIN_EN: rotate the search pointer so the last
// owner becomes lowest priority; otherwise fixed highest-index priority.
module arbiter8_priority_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  logic [0:0]       state_q,    state_d;
  logic [N_REQ-1:0] gnt_q,      gnt_d;
  logic [ID_W-1:0]  gntId_q,    gntId_d;
  logic             gntValid_q, gntValid_d;
  logic             timeout_q,  timeout_d;
  logic [CNT_W-1:0] holdCnt_q,  holdCnt_d;

  logic [ID_W-1:0]  prioPtr;
  logic [ID_W-1:0]  pickId;
  logic             pickAny;
  logic             ownerReq;
  logic             cntTerm;
  logic             releaseNow;

  arb_rotate_pick uPick (
    .req (req),
    .ptr (prioPtr),
    .id  (pickId),
    .any (pickAny)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] prioPtr_q;

  // After each grant the search starts just below the new owner, so that
  // owner is considered last next time (3-bit subtraction wraps 0 -> 7).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prioPtr_q <= 3'd7;
    end else if (state_q == ST_IDLE && pickAny) begin
      prioPtr_q <= pickId - 3'd1;
    end
  end

  assign prioPtr = prioPtr_q;
`else
  assign prioPtr = 3'd7;
`endif

  assign ownerReq   = req[gntId_q];
  assign cntTerm    = (holdCnt_q == CNT_W'(MAX_HOLD - 1));
  assign releaseNow = done || !ownerReq || cntTerm;

  // Next-state logic: grant from IDLE on any request, release from GRANT on
  // done, owner drop or terminal count; timeout flags a counter-only release.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gntId_d    = gntId_q;
    gntValid_d = gntValid_q;
    timeout_d  = 1'b0;
    holdCnt_d  = holdCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          state_d         = ST_GRANT;
          gnt_d           = '0;
          gnt_d[pickId]   = 1'b1;
          gntId_d         = pickId;
          gntValid_d      = 1'b1;
          holdCnt_d       = '0;
        end
      end
      default: begin
        if (releaseNow) begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          gntId_d    = '0;
          gntValid_d = 1'b0;
          holdCnt_d  = '0;
          timeout_d  = cntTerm && !done && ownerReq;
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gntId_q    <= '0;
      gntValid_q <= 1'b0;
      timeout_q  <= 1'b0;
      holdCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gntId_q    <= gntId_d;
      gntValid_q <= gntValid_d;
      timeout_q  <= timeout_d;
      holdCnt_q  <= holdCnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gntId_q;
  assign gnt_valid = gntValid_q;
  assign timeout   = timeout_q;

endmodule
